// File: rtl/gamma_lut_loader_pkg.sv
// Shared types and gamma_bus bit positions for the gamma LUT loader.
package gamma_lut_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RAMP,
    FINISH
  } state_t;

  localparam int unsigned GB_PRESENT = 21;
  localparam int unsigned GB_CLK     = 20;
  localparam int unsigned GB_EN      = 19;
  localparam int unsigned GB_WR      = 18;
  localparam int unsigned GB_ADDR_HI = 17;
  localparam int unsigned GB_ADDR_LO = 8;

  localparam int unsigned ENTRIES_DEFAULT = 768;
  localparam int unsigned TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/gamma_lut_loader_stall.sv
// Stall watchdog: counts consecutive tick cycles, expires on the TIMEOUT-th.
module gamma_stall_watchdog #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  assign expire = tick & (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_sys) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/gamma_lut_loader.sv
// Loads the mixer gamma table from a byte stream or as an identity ramp.
// Optional trailing-checksum byte: define GAMMA_LUT_LOADER_CHKSUM_EN.
module gamma_lut_loader
  import gamma_lut_loader_pkg::*;
#(
  parameter int unsigned ENTRIES = ENTRIES_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk_sys,
  input  logic       reset,
  inout  wire [21:0] gamma_bus,
  input  logic       gamma_user_en,
  input  logic       load_start,
  input  logic       load_linear,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [9:0] LAST = 10'(ENTRIES - 1);

  state_t     state;
  logic       table_valid;
  logic       en;
  logic       wr;
  logic [9:0] addr;
  logic [7:0] value;
  logic [9:0] idx;
  logic       present;
  logic       accept;
  logic       cmd_go;
  logic       expire;

`ifdef GAMMA_LUT_LOADER_CHKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_next;
  logic       chk_phase;
  assign sum_next = sum + s_data;
`endif

  assign present = gamma_bus[GB_PRESENT];
  assign accept  = (state == LOAD) & s_valid & s_ready;
  assign cmd_go  = (state == IDLE) & present & (load_start | load_linear);

  assign gamma_bus[GB_CLK]                = clk_sys;
  assign gamma_bus[GB_EN]                 = en;
  assign gamma_bus[GB_WR]                 = wr;
  assign gamma_bus[GB_ADDR_HI:GB_ADDR_LO] = addr;
  assign gamma_bus[7:0]                   = value;

  gamma_stall_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk_sys(clk_sys),
    .reset  (reset),
    .clear  ((state != LOAD) || accept),
    .tick   ((state == LOAD) && !accept),
    .expire (expire)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      s_ready     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      table_valid <= 1'b0;
      en          <= 1'b0;
      wr          <= 1'b0;
      addr        <= '0;
      value       <= '0;
      idx         <= '0;
`ifdef GAMMA_LUT_LOADER_CHKSUM_EN
      sum         <= '0;
      chk_phase   <= 1'b0;
`endif
    end else begin
      wr   <= 1'b0;
      done <= 1'b0;
      // cmd_go masks en in the same edge busy rises, so en never overlaps a write
      en   <= table_valid & gamma_user_en & ~busy & ~cmd_go;
      case (state)
        IDLE: begin
          if (cmd_go) begin
            table_valid <= 1'b0;
            error       <= 1'b0;
            idx         <= '0;
            busy        <= 1'b1;
`ifdef GAMMA_LUT_LOADER_CHKSUM_EN
            sum         <= '0;
            chk_phase   <= 1'b0;
`endif
            if (load_linear) begin
              state   <= RAMP;
              s_ready <= 1'b0;
            end else begin
              state   <= LOAD;
              s_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (!present || expire) begin
            state       <= IDLE;
            error       <= 1'b1;
            table_valid <= 1'b0;
            busy        <= 1'b0;
            s_ready     <= 1'b0;
          end else if (accept) begin
`ifdef GAMMA_LUT_LOADER_CHKSUM_EN
            if (chk_phase) begin
              s_ready <= 1'b0;
              if (sum_next == 8'h00) begin
                state <= FINISH;
              end else begin
                state       <= IDLE;
                error       <= 1'b1;
                table_valid <= 1'b0;
                busy        <= 1'b0;
              end
            end else
`endif
            begin
              wr    <= 1'b1;
              addr  <= idx;
              value <= s_data;
`ifdef GAMMA_LUT_LOADER_CHKSUM_EN
              sum   <= sum_next;
`endif
              if (idx == LAST) begin
`ifdef GAMMA_LUT_LOADER_CHKSUM_EN
                chk_phase <= 1'b1;
`else
                s_ready   <= 1'b0;
                state     <= FINISH;
`endif
              end else begin
                idx <= idx + 10'd1;
              end
            end
          end
        end
        RAMP: begin
          if (!present) begin
            state       <= IDLE;
            error       <= 1'b1;
            table_valid <= 1'b0;
            busy        <= 1'b0;
          end else begin
            wr    <= 1'b1;
            addr  <= idx;
            value <= idx[7:0];
            if (idx == LAST) begin
              state <= FINISH;
            end else begin
              idx <= idx + 10'd1;
            end
          end
        end
        FINISH: begin
          table_valid <= 1'b1;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
